// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the UART receive FIFO.
package uart_rx_fifo_pkg;

    localparam int UART_RX_FIFO_ADDR_W = 8;
    localparam int BYTE_W              = 8;
    localparam int DROP_CNT_W          = 8;

    // Saturating increment so a long overrun never wraps back to a small count.
    function automatic logic [DROP_CNT_W-1:0] drop_cnt_inc(input logic [DROP_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Simple dual-port byte RAM, synchronous write and registered read; maps onto SB_RAM40_4K.
module uart_rx_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = UART_RX_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: block-RAM ring with a prefetched head register (first-word-fall-through),
// level count and a sticky overflow flag with saturating drop counter.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = UART_RX_FIFO_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic [BYTE_W-1:0]     rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_W+1:0]     count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              out_valid;
    logic              out_loaded;
    logic [BYTE_W-1:0] ram_q;
    logic              wr_accept;
    logic              wr_drop;
    logic              prefetch;

    // Status depends only on registers, so wr_valid/rd_en never reach empty/full/count.
    assign full      = (mem_cnt == (ADDR_W+1)'(DEPTH));
    assign empty     = !out_valid;
    assign count     = (ADDR_W+2)'(mem_cnt) + (ADDR_W+2)'(out_valid);
    assign wr_accept = wr_valid && !full;
    assign wr_drop   = wr_valid && full;
    assign prefetch  = (mem_cnt != '0) && (!out_valid || rd_en);

    // The RAM read register is the head register; it only reloads on prefetch, so the byte
    // stays put until popped. It has no reset, hence the mask until the first load.
    assign rd_data = out_loaded ? ram_q : '0;

    uart_rx_fifo_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept && resetn),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (prefetch && resetn),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            out_valid  <= 1'b0;
            out_loaded <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (prefetch) begin
                rd_ptr     <= rd_ptr + 1'b1;
                out_valid  <= 1'b1;
                out_loaded <= 1'b1;
            end else if (rd_en && out_valid) begin
                out_valid <= 1'b0;
            end

            case ({wr_accept, prefetch})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: ;
            endcase

            // A drop in the same cycle as a clear wins: the flag stays set and the count restarts at one.
            if (wr_drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt_inc(clr_overflow ? '0 : drop_cnt);
            end else if (clr_overflow) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk          = 1'b0;
    logic              resetn       = 1'b0;
    logic [7:0]        wr_data      = 8'h00;
    logic              wr_valid     = 1'b0;
    logic              rd_en        = 1'b0;
    logic              clr_overflow = 1'b0;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W+1:0] count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    uart_rx_fifo dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every byte held, in order; whether the oldest is on display; last shown byte.
    byte unsigned q[$];
    bit           shown  = 1'b0;
    int           m_rd   = 0;
    bit           m_ovf  = 1'b0;
    int           m_drop = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One clock edge of the FIFO's rules, applied to the values the inputs hold at that edge.
    task automatic model_edge();
        int  in_ram;
        bit  drop;
        if (!resetn) begin
            q.delete();
            shown  = 1'b0;
            m_rd   = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            in_ram = q.size() - (shown ? 1 : 0);
            drop   = wr_valid && (in_ram == DEPTH);
            if (rd_en && shown) begin
                void'(q.pop_front());
                shown = 1'b0;
            end
            if (!shown && in_ram > 0) begin
                shown = 1'b1;
                m_rd  = q[0];
            end
            if (wr_valid && !drop) q.push_back(wr_data);
            if (drop) begin
                m_ovf  = 1'b1;
                m_drop = clr_overflow ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (clr_overflow) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("empty", int'(empty), shown ? 0 : 1);
        check("full", int'(full), ((q.size() - (shown ? 1 : 0)) == DEPTH) ? 1 : 0);
        check("count", int'(count), q.size());
        check("rd_data", int'(rd_data), m_rd);
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    // Drive inputs at a falling edge, let one rising edge consume them, compare at the next falling edge.
    task automatic tick(input bit wv, input logic [7:0] wd, input bit re, input bit clr);
        wr_valid     = wv;
        wr_data      = wd;
        rd_en        = re;
        clr_overflow = clr;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nxt;
        @(negedge clk);
        resetn = 1'b0;
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 0, 0);
        check("reset_empty", int'(empty), 1);
        check("reset_count", int'(count), 0);
        check("reset_rd_data", int'(rd_data), 0);
        resetn = 1'b1;

        // Single byte: visible one edge after the write, gone after one pop.
        tick(1, 8'h41, 0, 0);
        check("t1_empty_at_N", int'(empty), 1);
        tick(0, 8'h00, 0, 0);
        check("t1_empty_N1", int'(empty), 0);
        check("t1_rd_data", int'(rd_data), 8'h41);
        check("t1_count", int'(count), 1);
        tick(0, 8'h00, 1, 0);
        check("t1_pop_empty", int'(empty), 1);
        check("t1_pop_count", int'(count), 0);

        // Burst of five, drained with rd_en held.
        for (int i = 0; i < 5; i++) tick(1, 8'(8'h10 + i), 0, 0);
        check("t2_count5", int'(count), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_seq", int'(rd_data), 8'h10 + i);
            check("t2_not_empty", int'(empty), 0);
            tick(0, 8'h00, 1, 0);
        end
        check("t2_drained", int'(empty), 1);
        tick(0, 8'h00, 1, 0);
        check("t2_idle_pop_count", int'(count), 0);
        check("t2_idle_pop_data", int'(rd_data), 8'h14);

        // Fill to DEPTH+1, overrun by three, drain everything.
        for (int i = 0; i <= DEPTH; i++) tick(1, 8'(i), 0, 0);
        check("t3_full", int'(full), 1);
        check("t3_count", int'(count), DEPTH + 1);
        for (int i = 0; i < 3; i++) tick(1, 8'hEE, 0, 0);
        check("t3_overflow", int'(overflow), 1);
        check("t3_drop_cnt", int'(drop_cnt), 3);
        check("t3_count_kept", int'(count), DEPTH + 1);
        for (int i = 0; i <= DEPTH; i++) begin
            check("t3_drain_seq", int'(rd_data), i & 8'hFF);
            tick(0, 8'h00, 1, 0);
        end
        check("t3_drained", int'(empty), 1);
        check("t3_drained_count", int'(count), 0);
        tick(0, 8'h00, 0, 1);
        check("t3_clr_ovf", int'(overflow), 0);
        check("t3_clr_drop", int'(drop_cnt), 0);

        // Three in, three out, across pointer wrap.
        nxt = 0;
        for (int it = 0; it < 86; it++) begin
            for (int k = 0; k < 3; k++) begin
                tick(1, 8'(nxt + k), 0, 0);
                check("t4_count_le3", (count <= 3) ? 1 : 0, 1);
            end
            for (int k = 0; k < 3; k++) begin
                check("t4_seq", int'(rd_data), (nxt + k) & 8'hFF);
                tick(0, 8'h00, 1, 0);
                check("t4_count_le3", (count <= 3) ? 1 : 0, 1);
            end
            nxt += 3;
        end
        check("t4_empty", int'(empty), 1);

        // Full with pop and write together: pop happens, write dropped.
        for (int i = 0; i <= DEPTH; i++) tick(1, 8'(8'h80 + i), 0, 0);
        check("t5_full", int'(full), 1);
        tick(1, 8'hEE, 1, 0);
        check("t5_full_after_pop", int'(full), 0);
        check("t5_count_after_pop", int'(count), DEPTH);
        check("t5_overflow", int'(overflow), 1);
        check("t5_drop_cnt", int'(drop_cnt), 1);
        check("t5_next_head", int'(rd_data), 8'h81);
        tick(1, 8'hAB, 0, 0);
        check("t5_accept_count", int'(count), DEPTH + 1);
        check("t5_accept_full", int'(full), 1);
        tick(1, 8'hEE, 0, 0);
        tick(1, 8'hEE, 0, 0);
        check("t5_drop_cnt3", int'(drop_cnt), 3);
        tick(1, 8'hEE, 0, 1);
        check("t5_clr_vs_drop_ovf", int'(overflow), 1);
        check("t5_clr_vs_drop_cnt", int'(drop_cnt), 1);
        for (int i = 0; i < DEPTH + 2; i++) tick(0, 8'h00, 1, 0);
        check("t5_drained", int'(empty), 1);

        // Reset mid-stream with ten bytes held and overflow still set.
        for (int i = 0; i < 10; i++) tick(1, 8'(8'h60 + i), 0, 0);
        check("t6_count10", int'(count), 10);
        check("t6_ovf_before", int'(overflow), 1);
        resetn = 1'b0;
        tick(1, 8'h77, 0, 0);
        resetn = 1'b1;
        check("t6_count", int'(count), 0);
        check("t6_empty", int'(empty), 1);
        check("t6_overflow", int'(overflow), 0);
        check("t6_drop_cnt", int'(drop_cnt), 0);
        check("t6_rd_data", int'(rd_data), 0);
        tick(1, 8'h5A, 0, 0);
        check("t6_empty_at_N", int'(empty), 1);
        tick(0, 8'h00, 0, 0);
        check("t6_rd_data_5a", int'(rd_data), 8'h5A);
        check("t6_count1", int'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
